// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK counter sequencer: command ops, JK action
// codes and the controller state enum.
package jk_seq_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] jk_t;

  // Host command encodings on cmd_op
  localparam op_t OP_COUNT  = 2'b00;
  localparam op_t OP_CLEAR  = 2'b01;
  localparam op_t OP_PRESET = 2'b10;
  localparam op_t OP_RSVD   = 2'b11;

  // {J,K} action codes understood by the counter while en=1
  localparam jk_t JK_HOLD = 2'b00;
  localparam jk_t JK_CLR  = 2'b01;
  localparam jk_t JK_SET  = 2'b10;
  localparam jk_t JK_INC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/jk_counter_sequencer_if.sv
// Host-side command/status bundle of the sequencer. The host drives the
// command fields as master; the sequencer answers as slave.
interface jk_counter_sequencer_if
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_len;
  logic             stop;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, stop,
    input  cmd_ready, busy, done, aborted, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, stop,
    output cmd_ready, busy, done, aborted, err
  );

endinterface

// File: rtl/jk_counter_sequencer.sv
// Command-driven sequencer for an external JK binary counter. Turns COUNT,
// CLEAR and PRESET commands into per-cycle J/K/en drive, then compares the
// counter's value against the value the command should have produced.
module jk_counter_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_counter_sequencer_if.slave  cmd,
  input  logic [WIDTH-1:0]       ctr_count,
  output logic                   ctr_en,
  output logic                   ctr_j,
  output logic                   ctr_k,
  output logic                   ctr_rst_n
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  jk_t              jk_q, jk_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             ctr_rst_n_q, ctr_rst_n_d;
  logic             accept;

  // Command handshake: only take work once the counter is out of reset
  assign cmd.cmd_ready = (state_q == ST_IDLE) && ctr_rst_n_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state, register loads and abort pulse generation
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expected_d  = expected_q;
    jk_d        = jk_q;
    err_d       = err_q;
    aborted_d   = 1'b0;
    ctr_rst_n_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          case (cmd.cmd_op)
            OP_COUNT: begin
              if (cmd.cmd_len != '0) begin
                remaining_d = cmd.cmd_len;
                // Wraps naturally at WIDTH bits
                expected_d  = ctr_count + cmd.cmd_len;
                jk_d        = JK_INC;
                state_d     = ST_RUN;
              end else begin
                expected_d  = ctr_count;
                jk_d        = JK_HOLD;
                state_d     = ST_CHECK;
              end
            end
            OP_CLEAR: begin
              remaining_d = WIDTH'(1);
              expected_d  = '0;
              jk_d        = JK_CLR;
              state_d     = ST_RUN;
            end
            OP_PRESET: begin
              remaining_d = WIDTH'(1);
              expected_d  = '1;
              jk_d        = JK_SET;
              state_d     = ST_RUN;
            end
            default: begin
              // Reserved op completes without touching the counter
              jk_d    = JK_HOLD;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_RUN: begin
        remaining_d = remaining_q - WIDTH'(1);
        // Stop beats the last-cycle transition; the action driven this
        // cycle still lands because en is already on the wire.
        if (cmd.stop) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (remaining_q == WIDTH'(1)) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (ctr_count != expected_q) begin
          err_d = 1'b1;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and field registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      expected_q  <= '0;
      jk_q        <= JK_HOLD;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      ctr_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expected_q  <= expected_d;
      jk_q        <= jk_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
      ctr_rst_n_q <= ctr_rst_n_d;
    end
  end

  // Moore outputs decoded from state and registered fields
  always_comb begin
    ctr_en      = 1'b0;
    ctr_j       = 1'b0;
    ctr_k       = 1'b0;
    if (state_q == ST_RUN) begin
      ctr_en = 1'b1;
      ctr_j  = jk_q[1];
      ctr_k  = jk_q[0];
    end
  end

  assign ctr_rst_n   = ctr_rst_n_q;
  assign cmd.busy    = (state_q != ST_IDLE);
  assign cmd.done    = (state_q == ST_DONE);
  assign cmd.aborted = aborted_q;
  assign cmd.err     = err_q;

endmodule
